// File: rtl/axi3_defs_pkg.sv
// Shared AXI3 read-arbiter definitions: FSM state encoding, AR request bundle
// and burst-type constants.
package axi3_defs_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP = 2'b10;

    localparam int AXI_ID_W   = 4;
    localparam int AXI_ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_t;

    // Sized for the default arbiter configuration.
    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_ADDR_W-1:0] addr;
        logic [3:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
    } axi3_ar_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational N-way picker: the first requester found scanning upward from
// ptr (wrapping) wins. A ptr of 0 gives lowest-index-first fixed priority.
module rr_arbiter #(
    parameter int N     = 3,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W:0] pos;

    // Scan from the farthest offset down so the nearest requester is written last.
    always_comb begin
        grant = '0;
        idx   = '0;
        pos   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            pos = {1'b0, ptr} + (IDX_W + 1)'(i);
            if (pos >= (IDX_W + 1)'(N)) begin
                pos = pos - (IDX_W + 1)'(N);
            end
            if (req[pos[IDX_W-1:0]]) begin
                grant                 = '0;
                grant[pos[IDX_W-1:0]] = 1'b1;
                idx                   = pos[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/axi3_rd_arbiter.sv
// Shares one AXI3 read master among N requesters, one burst at a time, and
// flags RLAST/RID protocol errors. Define AXI3_RD_ARB_RR_EN for round-robin.
module axi3_rd_arbiter
    import axi3_defs_pkg::*;
#(
    parameter int N_MASTER   = 3,
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_MASTER*ID_WIDTH-1:0]   s_arid,
    input  logic [N_MASTER*ADDR_WIDTH-1:0] s_araddr,
    input  logic [N_MASTER*4-1:0]          s_arlen,
    input  logic [N_MASTER*3-1:0]          s_arsize,
    input  logic [N_MASTER*2-1:0]          s_arburst,
    input  logic [N_MASTER-1:0]            s_arvalid,
    output logic [N_MASTER-1:0]            s_arready,
    output logic [DATA_WIDTH-1:0]          s_rdata,
    output logic [ID_WIDTH-1:0]            s_rid,
    output logic [1:0]                     s_rresp,
    output logic                           s_rlast,
    output logic [N_MASTER-1:0]            s_rvalid,
    input  logic [N_MASTER-1:0]            s_rready,
    output logic [ID_WIDTH-1:0]            m_arid,
    output logic [ADDR_WIDTH-1:0]          m_araddr,
    output logic [3:0]                     m_arlen,
    output logic [2:0]                     m_arsize,
    output logic [1:0]                     m_arburst,
    output logic                           m_arvalid,
    input  logic                           m_arready,
    input  logic [ID_WIDTH-1:0]            m_rid,
    input  logic [DATA_WIDTH-1:0]          m_rdata,
    input  logic [1:0]                     m_rresp,
    input  logic                           m_rlast,
    input  logic                           m_rvalid,
    output logic                           m_rready,
    output logic                           len_err,
    output logic [1:0]                     dbg_state
);

    localparam int IDX_W = (N_MASTER > 1) ? $clog2(N_MASTER) : 1;

    arb_state_t           state;
    logic [IDX_W-1:0]     grant_idx;
    logic [IDX_W-1:0]     pick_idx;
    logic [IDX_W-1:0]     rr_ptr;
    logic [N_MASTER-1:0]  pick_onehot;
    logic [3:0]           pick_len;
    logic [ID_WIDTH-1:0]  pick_id;
    logic [3:0]           len_q;
    logic [ID_WIDTH-1:0]  id_q;
    logic [3:0]           beat_cnt;
    logic                 r_beat;

    logic [ID_WIDTH-1:0]   arid_a   [N_MASTER];
    logic [ADDR_WIDTH-1:0] araddr_a [N_MASTER];
    logic [3:0]            arlen_a  [N_MASTER];
    logic [2:0]            arsize_a [N_MASTER];
    logic [1:0]            arburst_a[N_MASTER];

    for (genvar gi = 0; gi < N_MASTER; gi++) begin : g_unpack
        assign arid_a[gi]    = s_arid[gi*ID_WIDTH +: ID_WIDTH];
        assign araddr_a[gi]  = s_araddr[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign arlen_a[gi]   = s_arlen[gi*4 +: 4];
        assign arsize_a[gi]  = s_arsize[gi*3 +: 3];
        assign arburst_a[gi] = s_arburst[gi*2 +: 2];
    end

    rr_arbiter #(.N(N_MASTER), .IDX_W(IDX_W)) u_pick (
        .req   (s_arvalid),
        .ptr   (rr_ptr),
        .grant (pick_onehot),
        .idx   (pick_idx)
    );

    always_comb begin
        pick_len = '0;
        pick_id  = '0;
        for (int i = 0; i < N_MASTER; i++) begin
            if (pick_onehot[i]) begin
                pick_len = pick_len | arlen_a[i];
                pick_id  = pick_id | arid_a[i];
            end
        end
    end

    assign r_beat    = m_rvalid & m_rready;
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            grant_idx <= '0;
            len_q     <= '0;
            id_q      <= '0;
            beat_cnt  <= '0;
            len_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|s_arvalid) begin
                        grant_idx <= pick_idx;
                        len_q     <= pick_len;
                        id_q      <= pick_id;
                        state     <= ADDR;
                    end
                end
                ADDR: begin
                    if (m_arready) begin
                        beat_cnt <= '0;
                        state    <= DATA;
                    end
                end
                DATA: begin
                    if (r_beat) begin
                        beat_cnt <= beat_cnt + 4'd1;
                        // RLAST must land exactly on beat ARLEN, and RID must echo ARID.
                        if ((m_rlast != (beat_cnt == len_q)) || (m_rid != id_q)) begin
                            len_err <= 1'b1;
                        end
                        if (m_rlast) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef AXI3_RD_ARB_RR_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= '0;
        end else if ((state == DATA) && r_beat && m_rlast) begin
            rr_ptr <= (grant_idx == IDX_W'(N_MASTER - 1)) ? '0 : grant_idx + 1'b1;
        end
    end
`else
    assign rr_ptr = '0;
`endif

    // Everything is zero outside its own phase, so reset forces all outputs low.
    always_comb begin
        m_arid    = '0;
        m_araddr  = '0;
        m_arlen   = '0;
        m_arsize  = '0;
        m_arburst = '0;
        m_arvalid = 1'b0;
        s_arready = '0;
        s_rvalid  = '0;
        s_rdata   = '0;
        s_rid     = '0;
        s_rresp   = '0;
        s_rlast   = 1'b0;
        m_rready  = 1'b0;
        case (state)
            ADDR: begin
                m_arid               = arid_a[grant_idx];
                m_araddr             = araddr_a[grant_idx];
                m_arlen              = arlen_a[grant_idx];
                m_arsize             = arsize_a[grant_idx];
                m_arburst            = arburst_a[grant_idx];
                m_arvalid            = 1'b1;
                s_arready[grant_idx] = m_arready;
            end
            DATA: begin
                s_rvalid[grant_idx] = m_rvalid;
                m_rready            = s_rready[grant_idx];
                s_rdata             = m_rdata;
                s_rid               = m_rid;
                s_rresp             = m_rresp;
                s_rlast             = m_rlast;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axi3_rd_arbiter.sv
// Directed bench for axi3_rd_arbiter: a vector table of single bursts plus
// hand-written arbitration and reset sequences. Build with or without AXI3_RD_ARB_RR_EN.
module tb_axi3_rd_arbiter;
    import axi3_defs_pkg::*;

    localparam int N  = 3;
    localparam int IW = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N*IW-1:0] s_arid;
    logic [N*AW-1:0] s_araddr;
    logic [N*4-1:0]  s_arlen;
    logic [N*3-1:0]  s_arsize;
    logic [N*2-1:0]  s_arburst;
    logic [N-1:0]    s_arvalid;
    logic [N-1:0]    s_arready;
    logic [DW-1:0]   s_rdata;
    logic [IW-1:0]   s_rid;
    logic [1:0]      s_rresp;
    logic            s_rlast;
    logic [N-1:0]    s_rvalid;
    logic [N-1:0]    s_rready;
    logic [IW-1:0]   m_arid;
    logic [AW-1:0]   m_araddr;
    logic [3:0]      m_arlen;
    logic [2:0]      m_arsize;
    logic [1:0]      m_arburst;
    logic            m_arvalid;
    logic            m_arready;
    logic [IW-1:0]   m_rid;
    logic [DW-1:0]   m_rdata;
    logic [1:0]      m_rresp;
    logic            m_rlast;
    logic            m_rvalid;
    logic            m_rready;
    logic            len_err;
    logic [1:0]      dbg_state;

    axi3_rd_arbiter #(
        .N_MASTER(N), .ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
    ) dut (
        .clk(clk), .rst(rst),
        .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
        .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rid(s_rid), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .s_rvalid(s_rvalid), .s_rready(s_rready),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_rvalid(m_rvalid), .m_rready(m_rready),
        .len_err(len_err), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int           n_checks = 0;
    int           n_pass   = 0;
    axi3_ar_req_t req_tab[N];
    logic [DW-1:0] exp_q[$];

    typedef struct {
        int            m;
        logic [AW-1:0] addr;
        logic [3:0]    len;
        logic [IW-1:0] id;
        logic [IW-1:0] rid;
        int            last_beat;
        bit            toggle;
        int            stall;
        logic [1:0]    burst;
        bit            pre_reset;
        bit            exp_err;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    function automatic logic [DW-1:0] pat(input int g, input int b);
        return DW'(32'hD000_0000 | (g << 8) | b);
    endfunction

    task automatic finish_run();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctrl"}, 64'({m_arvalid, m_rready, s_arready, s_rvalid, s_rlast, len_err,
                                   dbg_state, s_rid, s_rresp, m_arid, m_arlen, m_arsize, m_arburst}),
              64'(0));
        check({tag, "_data"}, {s_rdata, m_araddr}, 64'(0));
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_req(input int m, input logic v);
        s_arid[m*IW +: IW]   = req_tab[m].id;
        s_araddr[m*AW +: AW] = req_tab[m].addr;
        s_arlen[m*4 +: 4]    = req_tab[m].len;
        s_arsize[m*3 +: 3]   = req_tab[m].size;
        s_arburst[m*2 +: 2]  = req_tab[m].burst;
        s_arvalid[m]         = v;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        s_arvalid = '0;
        m_rvalid  = 1'b0;
        #2 rst = 1'b0;
        #1 check_zero("reset");
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Waits for m_arvalid, holds m_arready low for `stall` cycles, then accepts.
    task automatic ar_phase(input int stall, output int g, output int first_seen);
        int            waited;
        int            unstable;
        bit            seen;
        logic [AW-1:0] a0;
        logic [IW-1:0] id0;
        g = -1; first_seen = -1; waited = 0; unstable = 0; seen = 1'b0; a0 = '0; id0 = '0;
        for (int cyc = 0; cyc < 40 && g < 0; cyc++) begin
            @(negedge clk);
            m_arready = 1'b0;
            #1;
            if (m_arvalid) begin
                if (!seen) begin
                    seen = 1'b1; first_seen = cyc; a0 = m_araddr; id0 = m_arid;
                end else if (m_araddr !== a0 || m_arid !== id0) begin
                    unstable++;
                end
                if (s_arready !== '0) unstable++;
                if (waited >= stall) begin
                    m_arready = 1'b1;
                    #1;
                    for (int i = 0; i < N; i++) if (s_arready[i]) g = i;
                end
                waited++;
            end
        end
        if (stall > 0) check("ar_stable_during_stall", 64'(unstable), 64'(0));
        check("ar_handshake_seen", 64'(g >= 0), 64'(1));
        if (g < 0) begin
            $display("FAIL ar_phase: no AR handshake within budget, stopping");
            $display("%0d/%0d checks passed", n_pass, n_checks);
            $fatal(1);
        end
        check("ar_ready_onehot", 64'(s_arready), 64'(3'b001 << g));
        check("m_araddr", 64'(m_araddr), 64'(req_tab[g].addr));
        check("m_arid_len", 64'({m_arid, m_arlen}), 64'({req_tab[g].id, req_tab[g].len}));
        check("m_arsize_burst", 64'({m_arsize, m_arburst}), 64'({req_tab[g].size, req_tab[g].burst}));
    endtask

    // Downstream slave: presents beats 0..last_beat, RLAST on last_beat.
    task automatic r_phase(input int g, input int last_beat, input logic [IW-1:0] rid,
                           input bit toggle, input bit keep_req);
        int beat      = 0;
        bit done      = 1'b0;
        int route_err = 0;
        int data_err  = 0;
        int delivered = 0;
        for (int b = 0; b <= last_beat; b++) exp_q.push_back(pat(g, b));
        @(negedge clk);
        m_arready    = 1'b0;
        s_arvalid[g] = keep_req;
        for (int cyc = 0; cyc < 80 && !done; cyc++) begin
            m_rvalid    = 1'b1;
            m_rdata     = pat(g, beat);
            m_rlast     = (beat == last_beat);
            m_rid       = rid;
            m_rresp     = 2'(beat);
            s_rready    = '0;
            s_rready[g] = toggle ? (cyc % 2 == 0) : 1'b1;
            #1;
            if (s_rvalid !== (3'b001 << g)) route_err++;
            if (m_rready !== s_rready[g]) route_err++;
            if (s_rlast !== m_rlast || s_rid !== m_rid || s_rresp !== m_rresp) route_err++;
            if (s_rvalid[g] && s_rready[g]) begin
                delivered++;
                if (exp_q.size() == 0) data_err++;
                else if (exp_q.pop_front() !== s_rdata) data_err++;
            end
            if (m_rready) begin
                if (m_rlast) done = 1'b1;
                beat++;
            end
            @(negedge clk);
        end
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        s_rready = '0;
        #1;
        check("r_routing", 64'(route_err), 64'(0));
        check("r_data_order", 64'(data_err), 64'(0));
        check("r_beat_count", 64'(delivered), 64'(last_beat + 1));
        check("r_queue_drained", 64'(exp_q.size()), 64'(0));
        check("fsm_idle_after_burst", 64'(dbg_state), 64'(IDLE));
        exp_q.delete();
    endtask

    // ---------------- test ----------------
    int g;
    int first;
    int want[N];
    int exp_order[4];

    initial begin
        s_arid = '0; s_araddr = '1; s_arlen = '1; s_arsize = '1; s_arburst = '1;
        s_arvalid = '0; s_rready = '1;
        m_arready = 1'b1; m_rid = '1; m_rdata = '1; m_rresp = '1; m_rlast = 1'b1; m_rvalid = 1'b1;
        #2 rst = 1'b0;
        #1 check_zero("por");
        repeat (2) @(negedge clk);
        m_rvalid = 1'b0; m_rlast = 1'b0; m_arready = 1'b0; s_rready = '0;
        rst = 1'b1;

        // m, addr, len, id, rid, last_beat, toggle, stall, burst, pre_reset, exp_err
        vecs[0] = '{0, 32'h1000_0000, 4'd7,  4'h1, 4'h1, 7,  1'b0, 0, AXI_BURST_INCR, 1'b0, 1'b0};
        vecs[1] = '{1, 32'h2000_0040, 4'd3,  4'h3, 4'h3, 3,  1'b1, 5, AXI_BURST_INCR, 1'b0, 1'b0};
        vecs[2] = '{2, 32'h3000_0100, 4'd0,  4'h6, 4'h6, 0,  1'b0, 0, AXI_BURST_INCR, 1'b0, 1'b0};
        vecs[3] = '{1, 32'h2000_1000, 4'd15, 4'hF, 4'hF, 15, 1'b0, 1, AXI_BURST_INCR, 1'b0, 1'b0};
        vecs[4] = '{0, 32'h1000_0200, 4'd3,  4'h1, 4'h1, 2,  1'b0, 0, AXI_BURST_INCR, 1'b0, 1'b1};
        vecs[5] = '{2, 32'h3000_0300, 4'd3,  4'h6, 4'h6, 3,  1'b0, 0, AXI_BURST_WRAP, 1'b0, 1'b1};
        vecs[6] = '{2, 32'h3000_0400, 4'd1,  4'h2, 4'h5, 1,  1'b0, 0, AXI_BURST_INCR, 1'b1, 1'b1};
        vecs[7] = '{1, 32'h2000_0500, 4'd1,  4'h3, 4'h3, 2,  1'b1, 0, AXI_BURST_INCR, 1'b1, 1'b1};
        vecs[8] = '{0, 32'h1000_0600, 4'd2,  4'h7, 4'h7, 2,  1'b0, 0, AXI_BURST_INCR, 1'b1, 1'b0};

        for (int k = 0; k < 9; k++) begin
            if (vecs[k].pre_reset) apply_reset();
            req_tab[vecs[k].m] = '{id: vecs[k].id, addr: vecs[k].addr, len: vecs[k].len,
                                   size: 3'd2, burst: vecs[k].burst};
            set_req(vecs[k].m, 1'b1);
            ar_phase(vecs[k].stall, g, first);
            check($sformatf("v%0d_grant", k), 64'(g), 64'(vecs[k].m));
            check($sformatf("v%0d_ar_next_cycle", k), 64'(first), 64'(0));
            r_phase(g, vecs[k].last_beat, vecs[k].rid, vecs[k].toggle, 1'b0);
            check($sformatf("v%0d_len_err", k), 64'(len_err), 64'(vecs[k].exp_err));
        end

        // Simultaneous requests: round 1 everyone once, round 2 master 0 twice.
        apply_reset();
        for (int i = 0; i < N; i++) begin
            req_tab[i] = '{id: IW'(8 + i), addr: 32'h4000_0000 + 32'(i << 12), len: 4'd0,
                           size: 3'd2, burst: AXI_BURST_INCR};
        end
        want = '{1, 1, 1};
        for (int i = 0; i < N; i++) set_req(i, 1'b1);
        for (int k = 0; k < 3; k++) begin
            ar_phase(0, g, first);
            check($sformatf("round1_grant%0d", k), 64'(g), 64'(k));
            check($sformatf("round1_b2b%0d", k), 64'(first), 64'(0));
            want[g]--;
            r_phase(g, 0, req_tab[g].id, 1'b0, want[g] > 0);
        end
        want = '{2, 1, 1};
`ifdef AXI3_RD_ARB_RR_EN
        exp_order = '{0, 1, 2, 0};
`else
        exp_order = '{0, 0, 1, 2};
`endif
        for (int i = 0; i < N; i++) set_req(i, 1'b1);
        for (int k = 0; k < 4; k++) begin
            ar_phase(0, g, first);
            check($sformatf("round2_grant%0d", k), 64'(g), 64'(exp_order[k]));
            check($sformatf("round2_b2b%0d", k), 64'(first), 64'(0));
            want[g]--;
            r_phase(g, 0, req_tab[g].id, 1'b0, want[g] > 0);
        end
        check("arb_len_err_clean", 64'(len_err), 64'(0));

        // Reset mid-burst: master 0 completes first so a round-robin pointer would be non-zero.
        req_tab[0] = '{id: 4'h1, addr: 32'h5000_0000, len: 4'd0, size: 3'd2, burst: AXI_BURST_INCR};
        set_req(0, 1'b1);
        ar_phase(0, g, first);
        r_phase(g, 0, req_tab[g].id, 1'b0, 1'b0);
        req_tab[1] = '{id: 4'h4, addr: 32'h5100_0000, len: 4'd7, size: 3'd2, burst: AXI_BURST_INCR};
        set_req(1, 1'b1);
        ar_phase(0, g, first);
        check("midrst_grant", 64'(g), 64'(1));
        @(negedge clk);
        m_arready = 1'b0; s_arvalid[1] = 1'b0; s_rready = 3'b010;
        m_rvalid = 1'b1; m_rlast = 1'b0; m_rid = 4'h4;
        for (int b = 0; b < 3; b++) begin
            m_rdata = pat(1, b);
            if (b < 2) @(negedge clk);
        end
        #1;
        check("midrst_beat2_routed", 64'({s_rvalid, s_rdata}), 64'({3'b010, pat(1, 2)}));
        #1 rst = 1'b0;
        #1 check_zero("midrst");
        @(negedge clk);
        m_rvalid = 1'b0; s_rready = '0;
        rst = 1'b1;
        req_tab[1] = '{id: 4'h5, addr: 32'h5200_0000, len: 4'd1, size: 3'd2, burst: AXI_BURST_INCR};
        set_req(0, 1'b1);
        set_req(1, 1'b1);
        ar_phase(0, g, first);
        check("postrst_first_grant", 64'(g), 64'(0));
        r_phase(g, 0, req_tab[g].id, 1'b0, 1'b0);
        ar_phase(0, g, first);
        check("postrst_second_grant", 64'(g), 64'(1));
        r_phase(g, 1, req_tab[g].id, 1'b0, 1'b0);
        check("postrst_len_err", 64'(len_err), 64'(0));

        finish_run();
    end

endmodule

// File: doc/axi3_rd_arbiter.md
# axi3_rd_arbiter

Shares one AXI3 read master port among N cache-side read requesters: icache, dcache cached, dcache uncached. Sits between the cache controller and the SoC interconnect so the core exposes a single AXI3 read channel. Serialises bursts, one outstanding read at a time. Routes R beats back to the granted requester and checks burst length.

## Interface
- N_MASTER, 3, number of requesters; index 0 = icache, 1 = dcache cached, 2 = dcache uncached
- ID_WIDTH, 4, AXI ID width
- ADDR_WIDTH, 32, AXI address width
- DATA_WIDTH, 32, AXI data width
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- s_arid  in  N_MASTER×ID_WIDTH  per-requester ARID
- s_araddr  in  N_MASTER×ADDR_WIDTH  per-requester ARADDR
- s_arlen  in  N_MASTER×4  per-requester ARLEN (beats−1)
- s_arsize  in  N_MASTER×3  per-requester ARSIZE
- s_arburst  in  N_MASTER×2  per-requester ARBURST
- s_arvalid  in  N_MASTER  per-requester ARVALID
- s_arready  out  N_MASTER  per-requester ARREADY
- s_rdata  out  DATA_WIDTH  shared RDATA broadcast
- s_rid  out  ID_WIDTH  shared RID broadcast
- s_rresp  out  2  shared RRESP broadcast
- s_rlast  out  1  shared RLAST broadcast
- s_rvalid  out  N_MASTER  per-requester RVALID, one-hot or zero
- s_rready  in  N_MASTER  per-requester RREADY
- m_arid, m_araddr, m_arlen, m_arsize, m_arburst  out  ID_WIDTH, ADDR_WIDTH, 4, 3, 2  downstream AR fields
- m_arvalid  out  1;  m_arready  in  1
- m_rid, m_rdata, m_rresp, m_rlast, m_rvalid  in  ID_WIDTH, DATA_WIDTH, 2, 1, 1
- m_rready  out  1
- len_err  out  1  sticky: RLAST on wrong beat or missing at final beat, or RID ≠ granted ARID

## Operation
- FSM states IDLE, ADDR, DATA.
- IDLE: if any s_arvalid, pick winner g and register grant, ARLEN and ARID. Go to ADDR next cycle. m_arvalid=0, m_rready=0, all s_arready=0.
- ADDR: m_ar* = s_ar*[g]; m_arvalid=1; s_arready[g]=m_arready, others 0. On m_arvalid&m_arready go to DATA and clear beat counter.
- DATA: s_rvalid[g]=m_rvalid, others 0; m_rready=s_rready[g]; s_r* fields pass through. Each handshake increments a 4-bit beat counter.
  - On a handshake with m_rlast=1, return to IDLE.
  - Set len_err if rlast=1 with counter ≠ ARLEN, or rlast=0 with counter = ARLEN, or m_rid ≠ stored ARID.
  - On rlast without count match, still return to IDLE.
- Outside DATA, m_rready=0; stray R beats are stalled, never dropped.
- A requester drops arvalid before grant: it simply loses arbitration. Dropping after ADDR entry is an AXI violation; behaviour is undefined.
- Reset (asynchronous, any state, including mid-burst): state=IDLE, grant=0, counter=0, RR pointer=0, len_err=0, all outputs 0. Any in-flight burst is abandoned.

## Timing
- s_arvalid asserted in cycle 0 with arbiter in IDLE → m_arvalid=1 in cycle 1.
- AR fields are combinational from the granted requester. R path is combinational.
- Back-to-back bursts: one IDLE cycle after the last beat.
- Minimum cost of an N-beat burst: 1 (IDLE) + 1 (ADDR, when m_arready=1) + N cycles.
- Simultaneous requests: resolved in IDLE by policy (see Configuration). Losers keep arvalid high and win later.

## Configuration
- AXI3_RD_ARB_RR_EN defined: round-robin arbitration.
  - After each completed burst, the pointer becomes g+1 mod N_MASTER.
  - Search starts at the pointer, so no starvation.
- Undefined: fixed priority, lowest index wins (icache > dcache cached > dcache uncached). The pointer register is not synthesised.

## Structure
- Shared package axi3_defs_pkg holds:
  - arb_state_t enum (IDLE/ADDR/DATA)
  - axi3_ar_req_t struct (id, addr, len, size, burst)
  - AXI_BURST_INCR and AXI_BURST_WRAP constants
- One sub-module, rr_arbiter: combinational N-way picker. Takes request vector and start pointer; outputs one-hot grant and encoded index. A pointer of 0 gives fixed priority.

## Test plan
- Single request: master 0 issues addr 0x1000_0000, len 7 → m_arvalid in cycle 1; 8 beats appear only on s_rvalid[0]; FSM back to IDLE; len_err=0.
- Simultaneous requests: all three assert together.
  - RR build: grant order 0,1,2; a second round from 0 yields 0,1,2 again.
  - Fixed build: master 0 reasserting continuously starves 1 and 2.
- Backpressure: m_arready low 5 cycles, then s_rready[1] toggling every cycle during a len=3 burst.
  - AR fields stay stable; exactly 4 beats delivered; no beat lost or duplicated.
- Length error: len=3 granted, downstream asserts rlast on beat 2 → len_err=1 and stays 1; FSM returns to IDLE; next burst proceeds.
- RID mismatch: ARID=2, downstream returns RID=5 → len_err=1.
- Reset mid-burst: rst low during beat 2 of 8 → all outputs 0 asynchronously. After release, a new request completes normally with pointer 0 (master 0 first).
